// File: rtl/branch_resolve_unit.sv
// Resolution end of the gshare predictor: carries prediction and target D->E->M,
// resolves in M, drives the predictor update port, fetch redirect and flush control.
module branch_resolve_unit #(
    parameter int PC_W         = 32,
    parameter int DELAY_SLOT   = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             branchD,
    input  logic             pred_takeD,
    input  logic [PC_W-1:0]  pcD,
    input  logic [PC_W-1:0]  targetD,
    input  logic             actual_takeE,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_req,
    output logic             upd_valid,
    output logic [PC_W-1:0]  upd_pc,
    output logic             upd_taken,
    output logic             upd_correct,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [PC_W-1:0]  FALL_OFS    = (DELAY_SLOT != 0) ? PC_W'(8) : PC_W'(4);
    localparam logic [2:0]       FC_INIT     = 3'(FLUSH_CYCLES - 1);
    localparam bit               USE_RECOVER = (FLUSH_CYCLES > 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

    typedef enum logic {
        ST_NORMAL  = 1'b0,
        ST_RECOVER = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       fc_q, fc_d;

    logic             valid_e_q, valid_e_d;
    logic             pred_e_q, pred_e_d;
    logic [PC_W-1:0]  pc_e_q, pc_e_d;
    logic [PC_W-1:0]  target_e_q, target_e_d;

    logic             valid_m_q, valid_m_d;
    logic             pred_m_q, pred_m_d;
    logic             taken_m_q, taken_m_d;
    logic [PC_W-1:0]  pc_m_q, pc_m_d;
    logic [PC_W-1:0]  target_m_q, target_m_d;

    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic             in_normal;
    logic             res;
    logic             mispred;
    logic             flush;

    // Resolution is suppressed during RECOVER, and a stalled M only resolves on release.
    assign in_normal = (state_q == ST_NORMAL);
    assign res       = valid_m_q & ~stall & in_normal;
    assign mispred   = res & (pred_m_q != taken_m_q);
    assign flush     = mispred | ~in_normal;

    assign redirect_valid = mispred;
    assign redirect_pc    = taken_m_q ? target_m_q : (pc_m_q + FALL_OFS);
    assign flush_req      = flush;
    assign upd_valid      = res;
    assign upd_pc         = pc_m_q;
    assign upd_taken      = taken_m_q;
    assign upd_correct    = res & ~mispred;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

    always_comb begin
        valid_e_d  = valid_e_q;
        pred_e_d   = pred_e_q;
        pc_e_d     = pc_e_q;
        target_e_d = target_e_q;
        valid_m_d  = valid_m_q;
        pred_m_d   = pred_m_q;
        taken_m_d  = taken_m_q;
        pc_m_d     = pc_m_q;
        target_m_d = target_m_q;
        // Flush wins over stall: wrong-path branches never survive a flush cycle.
        if (flush) begin
            valid_e_d = 1'b0;
            valid_m_d = 1'b0;
        end else if (!stall) begin
            valid_m_d  = valid_e_q;
            pred_m_d   = pred_e_q;
            taken_m_d  = actual_takeE;
            pc_m_d     = pc_e_q;
            target_m_d = target_e_q;
            valid_e_d  = branchD;
            pred_e_d   = pred_takeD & branchD;
            pc_e_d     = pcD;
            target_e_d = targetD;
        end
    end

    always_comb begin
        state_d = state_q;
        fc_d    = fc_q;
        case (state_q)
            ST_NORMAL: begin
                if (mispred && USE_RECOVER) begin
                    state_d = ST_RECOVER;
                    fc_d    = FC_INIT;
                end
            end
            ST_RECOVER: begin
                if (!stall) begin
                    if (fc_q <= 3'd1) begin
                        state_d = ST_NORMAL;
                        fc_d    = 3'd0;
                    end else begin
                        fc_d = fc_q - 3'd1;
                    end
                end
            end
            default: begin
                state_d = ST_NORMAL;
                fc_d    = 3'd0;
            end
        endcase
    end

    always_comb begin
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (res && (branch_cnt_q != CNT_MAX)) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end
        if (mispred && (mispred_cnt_q != CNT_MAX)) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_NORMAL;
            fc_q          <= 3'd0;
            valid_e_q     <= 1'b0;
            pred_e_q      <= 1'b0;
            pc_e_q        <= '0;
            target_e_q    <= '0;
            valid_m_q     <= 1'b0;
            pred_m_q      <= 1'b0;
            taken_m_q     <= 1'b0;
            pc_m_q        <= '0;
            target_m_q    <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            state_q       <= state_d;
            fc_q          <= fc_d;
            valid_e_q     <= valid_e_d;
            pred_e_q      <= pred_e_d;
            pc_e_q        <= pc_e_d;
            target_e_q    <= target_e_d;
            valid_m_q     <= valid_m_d;
            pred_m_q      <= pred_m_d;
            taken_m_q     <= taken_m_d;
            pc_m_q        <= pc_m_d;
            target_m_q    <= target_m_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule
